// File: rtl/ysyx_2022040010_wb_arb.sv
// ysyx_2022040010_wb_arb
// Write-port arbiter and scoreboard for the integer register file. The single
// regfile write port is shared between the in-order pipeline writeback stream
// and a long-latency unit (mul/div) result stream. Long-latency results are
// buffered in a small FIFO and are guaranteed forward progress by a starvation
// counter. A per-register busy scoreboard lets ID stall on RAW hazards against
// outstanding long-latency writes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pipe_we/waddr/wdata      pipeline writeback request
//   pipe_stall               buffer is being forced through; pipeline must hold
//   lu_valid/waddr/wdata     long-latency result
//   lu_ready                 result buffer can accept (combinational)
//   issue_valid/issue_rd     long-latency op issued from ID this cycle
//   busy                     pending long-latency write per register (bit 0 = 0)
//   rf_we/waddr/wdata        registered regfile write port
module ysyx_2022040010_wb_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [63:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [63:0] lu_wdata,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } lu_entry_t;

  lu_entry_t          mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      starve_cnt;

  logic               empty;
  logic               full;
  lu_entry_t          head;
  logic               pipe_req;
  logic               force_grant;
  logic               buf_grant;
  logic               pipe_grant;
  logic               push;
  logic [CW-1:0]      starve_nxt;
  logic [31:0]        busy_nxt;

  // FIFO status: pointers carry one wrap bit beyond the index width.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    head  = mem[rd_ptr[AW-1:0]];
  end

  // lu_ready is held low during reset so nothing is accepted into a FIFO
  // that is being cleared.
  assign lu_ready = !full && !rst;
  assign push     = lu_valid && lu_ready;

  // Grant selection; force depends on registered state only.
  always_comb begin
    pipe_req    = pipe_we && (pipe_waddr != 5'd0);
    force_grant = !empty && (starve_cnt == CW'(STARVE_MAX));
    buf_grant   = force_grant || (!pipe_req && !empty);
    pipe_grant  = !force_grant && pipe_req;
  end

  assign pipe_stall = force_grant;

  // Starvation counter: counts pipeline wins while the buffer waits.
  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || buf_grant) begin
      starve_nxt = '0;
    end else if (pipe_grant && (starve_cnt != CW'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + CW'(1);
    end
  end

  // Scoreboard update; a same-cycle set overrides the clear.
  always_comb begin
    busy_nxt = busy;
    if (buf_grant) begin
      busy_nxt[head.waddr] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{waddr: lu_waddr, wdata: lu_wdata};
    end
  end

  // FIFO pointers, starvation counter and scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (buf_grant) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      starve_cnt <= starve_nxt;
      busy       <= busy_nxt;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  // A popped x0 entry is discarded without touching the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (buf_grant) begin
        if (head.waddr != 5'd0) begin
          rf_we    <= 1'b1;
          rf_waddr <= head.waddr;
          rf_wdata <= head.wdata;
        end
      end else if (pipe_grant) begin
        rf_we    <= 1'b1;
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_wb_arb.sv
// Self-checking bench for ysyx_2022040010_wb_arb: directed scenarios followed
// by a randomized run against a queue-based reference model.
module tb_ysyx_2022040010_wb_arb;

  localparam int unsigned SM    = 4;
  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [63:0] pipe_wdata;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [63:0] lu_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  ysyx_2022040010_wb_arb #(.STARVE_MAX(SM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending results as a queue, consecutive losses as an int.
  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  int          lost;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;

  function automatic bit m_stall();
    return (mq.size() != 0) && (lost == int'(SM));
  endfunction

  function automatic bit m_ready();
    return mq.size() < int'(DEPTH);
  endfunction

  function automatic void m_reset();
    mq.delete();
    lost    = 0;
    m_busy  = '0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endfunction

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [63:0] pd,
                       input logic lv, input logic [4:0] la, input logic [63:0] ld,
                       input logic iv, input logic [4:0] ir);
    pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    issue_valid = iv; issue_rd = ir;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  // Advance the model by one cycle from the current inputs, then clock the DUT.
  task automatic tick();
    bit   preq, frc, bg, rdy, was_empty;
    ent_t h;
    ent_t e;
    logic [31:0] nb;
    preq      = pipe_we && (pipe_waddr != 5'd0);
    frc       = m_stall();
    rdy       = m_ready();
    was_empty = (mq.size() == 0);
    bg        = frc || (!preq && !was_empty);
    nb        = m_busy;
    m_we      = 1'b0;
    if (bg) begin
      h = mq.pop_front();
      if (h.a != 5'd0) begin
        m_we = 1'b1; m_waddr = h.a; m_wdata = h.d;
      end
      nb[h.a] = 1'b0;
      lost = 0;
    end else if (preq) begin
      m_we = 1'b1; m_waddr = pipe_waddr; m_wdata = pipe_wdata;
      if (!was_empty && lost < int'(SM)) lost++;
    end
    if (was_empty) lost = 0;
    if (lu_valid && rdy) begin
      e.a = lu_waddr; e.d = lu_wdata;
      mq.push_back(e);
    end
    if (issue_valid && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    m_reset();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we); end
    n_tests++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0h expected 0", rf_waddr); end
    n_tests++; if (rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %0h expected 0", rf_wdata); end
    n_tests++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    n_tests++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lu_ready: got %0b expected 0", lu_ready); end
    n_tests++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_stall: got %0b expected 0", pipe_stall); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_tests++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL release_lu_ready: got %0b expected 1", lu_ready); end
  endtask

  task automatic test_pipe_write();
    drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    tick();
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL pipe_we: got %0b expected 1", rf_we); end
    n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL pipe_waddr: got %0h expected 5", rf_waddr); end
    n_tests++; if (rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL pipe_wdata: got %0h expected 1234", rf_wdata); end
    drive(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_x0_we: got %0b expected 0", rf_we); end
    n_tests++; if (rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL pipe_x0_hold: got %0h expected 1234", rf_wdata); end
  endtask

  task automatic test_lu_write();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    tick();
    n_tests++; if (busy[7] !== 1'b1) begin n_fail++; $display("FAIL lu_busy_set: got %0b expected 1", busy[7]); end
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAB, 1'b0, 5'd0);
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lu_push_cycle_we: got %0b expected 0", rf_we); end
    idle();
    tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'hAB)
      begin n_fail++; $display("FAIL lu_write: got we=%0b a=%0h d=%0h expected we=1 a=7 d=ab", rf_we, rf_waddr, rf_wdata); end
    n_tests++; if (busy[7] !== 1'b0) begin n_fail++; $display("FAIL lu_busy_clear: got %0b expected 0", busy[7]); end
  endtask

  task automatic test_starve();
    int wins;
    int guard;
    wins = 0;
    guard = 0;
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd12, 64'hC0FFEE, 1'b0, 5'd0);
    tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL starve_first: got we=%0b a=%0h expected we=1 a=3", rf_we, rf_waddr); end
    while (!pipe_stall && guard < 10) begin
      drive(1'b1, 5'(guard + 1), 64'(guard), 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
      tick();
      n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'(guard + 1))
        begin n_fail++; $display("FAIL starve_pipe: got we=%0b a=%0h expected we=1 a=%0h", rf_we, rf_waddr, 5'(guard + 1)); end
      wins++;
      guard++;
    end
    n_tests++; if (wins != int'(SM)) begin n_fail++; $display("FAIL starve_wins: got %0d expected %0d", wins, SM); end
    n_tests++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %0b expected 1", pipe_stall); end
    idle();
    tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 64'hC0FFEE)
      begin n_fail++; $display("FAIL starve_lu: got we=%0b a=%0h d=%0h expected we=1 a=c d=c0ffee", rf_we, rf_waddr, rf_wdata); end
    n_tests++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %0b expected 0", pipe_stall); end
  endtask

  task automatic test_fifo_full();
    int guard;
    guard = 0;
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd20, 64'hA, 1'b0, 5'd0);
    n_tests++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready0: got %0b expected 1", lu_ready); end
    tick();
    drive(1'b1, 5'd2, 64'h22, 1'b1, 5'd21, 64'hB, 1'b0, 5'd0);
    n_tests++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready1: got %0b expected 1", lu_ready); end
    tick();
    n_tests++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %0b expected 0", lu_ready); end
    while (!pipe_stall && guard < 10) begin
      drive(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
      n_tests++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_low: got %0b expected 0", lu_ready); end
      tick();
      guard++;
    end
    n_tests++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL full_no_force: got %0b expected 1", pipe_stall); end
    idle();
    tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 64'hA)
      begin n_fail++; $display("FAIL full_order0: got we=%0b a=%0h d=%0h expected we=1 a=14 d=a", rf_we, rf_waddr, rf_wdata); end
    n_tests++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise: got %0b expected 1", lu_ready); end
    idle();
    tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd21 || rf_wdata !== 64'hB)
      begin n_fail++; $display("FAIL full_order1: got we=%0b a=%0h d=%0h expected we=1 a=15 d=b", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_same_reg();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin n_fail++; $display("FAIL same_reg_write: got we=%0b a=%0h expected we=1 a=9", rf_we, rf_waddr); end
    n_tests++; if (busy[9] !== 1'b1) begin n_fail++; $display("FAIL same_reg_busy: got %0b expected 1", busy[9]); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; #1; rst = 1'b0; m_reset();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    tick();
    drive(1'b1, 5'd4, 64'h44, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
    tick();
    n_tests++; if (busy !== 32'h80) begin n_fail++; $display("FAIL mid_busy_pre: got %0h expected 80", busy); end
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_rf_we: got %0b expected 0", rf_we); end
    n_tests++; if (busy !== 32'd0) begin n_fail++; $display("FAIL mid_busy: got %0h expected 0", busy); end
    n_tests++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_lu_ready: got %0b expected 0", lu_ready); end
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      tick();
      n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_stale_write: got %0b expected 0 (cycle %0d)", rf_we, i); end
    end
  endtask

  task automatic test_random();
    logic       pwe, lv, iv;
    logic [4:0] pa, la, ir;
    for (int i = 0; i < 400; i++) begin
      pwe = !m_stall() && ($urandom_range(3) != 0);
      pa  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      lv  = ($urandom_range(2) == 0);
      la  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      iv  = ($urandom_range(3) == 0);
      ir  = 5'($urandom_range(31));
      drive(pwe, pa, {$urandom, $urandom}, lv, la, {$urandom, $urandom}, iv, ir);
      n_tests++; if (pipe_stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", i, pipe_stall, m_stall()); end
      n_tests++; if (lu_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", i, lu_ready, m_ready()); end
      tick();
      n_tests++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata)
        begin n_fail++; $display("FAIL rnd_rf[%0d]: got we=%0b a=%0h d=%0h expected we=%0b a=%0h d=%0h", i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); end
      n_tests++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %0h expected %0h", i, busy, m_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_lu_write();
    test_starve();
    test_fifo_full();
    test_same_reg();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_wb_arb.md
# ysyx_2022040010_wb_arb

Write-port arbiter and scoreboard for the integer register file. It shares the single regfile write port between the in-order pipeline writeback stream and a long-latency unit (mul/div) result stream. It buffers long-latency results in a small FIFO and prevents their starvation. It also tracks destination registers with outstanding long-latency writes so ID can stall on RAW hazards.

## Interface

- STARVE_MAX, default 4: consecutive lost arbitration cycles with a non-empty buffer before the buffer is forced to win; legal range 1..15.
- DEPTH, default 2: long-latency result buffer entries; power of two, 2..8.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pipe_we  in  1  pipeline writeback valid
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  64  pipeline write data
- pipe_stall  out  1  pipeline must not present a write this cycle (buffer forced grant)
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  buffer can accept a result
- lu_waddr  in  5  long-latency destination register
- lu_wdata  in  64  long-latency result data
- issue_valid  in  1  long-latency op issued from ID this cycle
- issue_rd  in  5  its destination register
- busy  out  32  per-register pending-write scoreboard; bit 0 always 0
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  5  regfile write address (registered)
- rf_wdata  out  64  regfile write data (registered)

## Operation

- pipe_req = pipe_we & (pipe_waddr != 0); a write to x0 is not a request and is never forwarded.
- Buffer: FIFO of {waddr, wdata}, DEPTH entries. lu_ready = !full & !rst. A push occurs on lu_valid & lu_ready.
- A push and a pop in the same cycle while full is not possible, because lu_ready is low whenever the FIFO is full.
- Grant, evaluated each cycle:
  - force = !empty & (starve_cnt == STARVE_MAX).
  - force: the buffer head wins. pipe_stall = 1 and pipe_we is ignored. Presenting pipe_we while pipe_stall is high is a protocol violation.
  - else pipe_req: the pipeline wins.
  - else !empty: the buffer head wins.
  - else: idle.
- pipe_stall = force. It is combinational from registered state only.
- Popped head with waddr 0: the entry is discarded, rf_we stays 0, and the pop still counts as a buffer grant.
- starve_cnt, 4 bits:
  - Cleared on a buffer grant or when the buffer is empty.
  - Increments when the buffer is non-empty and the pipeline wins.
  - Saturates at STARVE_MAX.
- Scoreboard:
  - Set: busy[issue_rd] on issue_valid & issue_rd != 0.
  - Clear: busy[head.waddr] on a buffer grant.
  - Same-register set and clear in the same cycle: set wins.
  - Re-issue to an already busy register leaves the bit at 1. Ordering is ID's responsibility.
- Pipeline writes never modify busy.

## Timing

- Reset (async assert): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO empty, starve_cnt=0, lu_ready=0, pipe_stall=0.
- After deassert, lu_ready=1 combinationally.
- Pipeline write: pipe_req at edge N → rf_* valid during cycle N+1 (1-cycle latency).
- LU result:
  - Pushed at edge N, so the earliest grant is in cycle N+1.
  - rf_* valid in cycle N+2, and the busy bit clears at the same edge rf_we rises.
  - ID forwards from rf_* that cycle.
- Idle cycles: rf_we=0; rf_waddr and rf_wdata hold their previous values.
- Worst-case LU latency with a continuous pipeline stream: the result waits STARVE_MAX cycles at the head, then one forced grant.
- Empty FIFO with lu_valid and pipe_req in the same cycle: push only. The pipeline wins, and the head becomes available next cycle.
- Reset mid-operation: buffered results are dropped and busy is cleared. The upstream flush is the system's responsibility.

## Test plan

- Reset, then pipe_we=1, waddr=5, data=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. A write with waddr=0 → rf_we=0.
- issue_valid with rd=7 → busy[7]=1. Then lu_valid with waddr=7, data=0xAB on an idle pipeline → 2 cycles later rf_we=1, addr=7, data=0xAB, and busy[7]=0 that cycle.
- Continuous pipe_req with one buffered LU result and STARVE_MAX=4 → 4 pipeline writes, then pipe_stall=1 for 1 cycle, the LU write is emitted, and starve_cnt returns to 0.
- DEPTH=2: push 2 results while pipe_req is high each cycle → lu_ready=0 after the second push. It rises the cycle after the first forced pop, and FIFO order is preserved.
- In the same cycle, issue_rd=9 and a buffer grant for waddr 9 → busy[9] remains 1.
- Assert rst mid-stream with the FIFO non-empty and busy=0x80 → immediately rf_we=0, busy=0, lu_ready=0. After release, no stale write appears.
